fetch_issue_pipelined: RTL

Parametrised instruction-fetch issue stage: holds the PC, issues read requests to the instruction memory through a valid/ready handshake, and tracks up to `INFLIGHT_DEPTH` outstanding requests in an in-order PC queue. Sits between the hazard/control unit, which supplies `next_PC_select` and `target_PC`, and fetch receive. Fetch receive gets the PC matching each returning instruction, plus a stale flag so it can squash wrong-path instructions after a redirect.

---
 rtl/fetch_issue_pipelined.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/fetch_issue_pipelined.sv
// fetch_issue_pipelined
// Instruction-fetch issue stage. Holds the PC, issues read requests to the
// instruction memory over a valid/ready handshake, and records the PC of
// every accepted request in an in-order queue so fetch receive can pair each
// returning instruction with its PC. A redirect marks all in-flight entries
// stale; they stay queued because the memory still returns their responses.
//
// Ports:
//   clock, reset          single clock, synchronous active-high reset
//   next_PC_select        00 increment, 01 stall, 10 redirect to target_PC,
//                         11 redirect to 0
//   target_PC             redirect target
//   i_mem_read            request valid (combinational)
//   i_mem_read_address    request address, always the PC register
//   i_mem_ready           memory accepts the request this cycle
//   i_mem_valid           one in-order response returns this cycle
//   issue_PC              PC of the oldest in-flight request (queue head)
//   issue_valid           response present and queue not empty
//   issue_stale           head belongs to a squashed path
//   inflight_count        occupied queue entries, 0..INFLIGHT_DEPTH
//   scan                  debug enable, no functional effect
module fetch_issue_pipelined #(
    parameter int CORE            = 0,
    parameter int RESET_PC        = 0,
    parameter int ADDRESS_BITS    = 32,
    parameter int INCREMENT       = 4,
    parameter int INFLIGHT_DEPTH  = 4,
    parameter int SCAN_CYCLES_MIN = 1,
    parameter int SCAN_CYCLES_MAX = 1000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [1:0]                      next_PC_select,
    input  logic [ADDRESS_BITS-1:0]         target_PC,
    output logic                            i_mem_read,
    output logic [ADDRESS_BITS-1:0]         i_mem_read_address,
    input  logic                            i_mem_ready,
    input  logic                            i_mem_valid,
    output logic [ADDRESS_BITS-1:0]         issue_PC,
    output logic                            issue_valid,
    output logic                            issue_stale,
    output logic [$clog2(INFLIGHT_DEPTH):0] inflight_count,
    input  logic                            scan
);

    localparam int PW = $clog2(INFLIGHT_DEPTH);
    localparam int CW = PW + 1;

    logic [ADDRESS_BITS-1:0]   pc_r;
    logic [ADDRESS_BITS-1:0]   pc_queue_r [INFLIGHT_DEPTH];
    logic [INFLIGHT_DEPTH-1:0] stale_r;
    logic [PW-1:0]             head_r;
    logic [PW-1:0]             tail_r;
    logic [CW-1:0]             count_r;
    logic [31:0]               cycle_r;

    logic                      read_s;
    logic                      fire_s;
    logic                      pop_s;
    logic                      redirect_s;
    logic [ADDRESS_BITS-1:0]   pc_next_s;
    logic [CW-1:0]             count_next_s;
    logic [INFLIGHT_DEPTH-1:0] occupied_s;
    logic [INFLIGHT_DEPTH-1:0] stale_next_s;
    logic                      scan_window_s;
    logic                      unused_s;

    // Requests are gated on the registered count, so a full queue never
    // issues even when a pop happens in the same cycle.
    assign redirect_s = next_PC_select[1];
    assign read_s     = !reset && (next_PC_select == 2'b00) &&
                        (count_r < CW'(INFLIGHT_DEPTH));
    assign fire_s     = read_s && i_mem_ready;
    // A response against an empty queue is a protocol violation and is dropped.
    assign pop_s      = i_mem_valid && (count_r != {CW{1'b0}});

    assign i_mem_read         = read_s;
    assign i_mem_read_address = pc_r;
    assign issue_PC           = pc_queue_r[head_r];
    assign issue_valid        = pop_s;
    // A response arriving in the redirect cycle is already on the wrong path.
    assign issue_stale        = stale_r[head_r] | redirect_s;
    assign inflight_count     = count_r;

    // Debug window qualifier; kept for observability, drives no logic.
    assign scan_window_s = scan && (cycle_r >= 32'(SCAN_CYCLES_MIN)) &&
                           (cycle_r <= 32'(SCAN_CYCLES_MAX));
    assign unused_s      = scan_window_s ^ (CORE < 32'sd0);

    // Next PC from the hazard/control select.
    always_comb begin
        pc_next_s = pc_r;
        case (next_PC_select)
            2'b00:   pc_next_s = fire_s ? (pc_r + ADDRESS_BITS'(INCREMENT)) : pc_r;
            2'b01:   pc_next_s = pc_r;
            2'b10:   pc_next_s = target_PC;
            2'b11:   pc_next_s = {ADDRESS_BITS{1'b0}};
            default: pc_next_s = pc_r;
        endcase
    end

    // Occupancy count: simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next_s = count_r;
        case ({fire_s, pop_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase
    end

    // Stale bits: redirect marks every occupied slot; popped and newly pushed
    // slots are cleared so an empty head never reports a leftover stale bit.
    always_comb begin
        occupied_s   = {INFLIGHT_DEPTH{1'b0}};
        stale_next_s = stale_r;
        for (int i = 0; i < INFLIGHT_DEPTH; i++) begin
            occupied_s[i]   = ({1'b0, PW'(i) - head_r} < count_r);
            stale_next_s[i] = stale_r[i] | (redirect_s & occupied_s[i]);
        end
        stale_next_s[head_r] = stale_next_s[head_r] & ~pop_s;
        stale_next_s[tail_r] = stale_next_s[tail_r] & ~fire_s;
    end

    // PC register and in-order PC queue.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_r    <= ADDRESS_BITS'(RESET_PC);
            head_r  <= {PW{1'b0}};
            tail_r  <= {PW{1'b0}};
            count_r <= {CW{1'b0}};
            stale_r <= {INFLIGHT_DEPTH{1'b0}};
            for (int i = 0; i < INFLIGHT_DEPTH; i++) begin
                pc_queue_r[i] <= {ADDRESS_BITS{1'b0}};
            end
        end else begin
            pc_r    <= pc_next_s;
            count_r <= count_next_s;
            stale_r <= stale_next_s;
            if (fire_s) begin
                pc_queue_r[tail_r] <= pc_r;
                tail_r             <= tail_r + PW'(1);
            end
            if (pop_s) begin
                head_r <= head_r + PW'(1);
            end
        end
    end

    // Saturating cycle counter for the debug scan window.
    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_r <= 32'd0;
        end else begin
            cycle_r <= (cycle_r == 32'hFFFF_FFFF) ? cycle_r : cycle_r + 32'd1;
        end
    end

endmodule
